// File: rtl/free_list.sv
// free_list
//   Physical-register free list for the rename stage. Hands out up to
//   FETCH_WIDTH destination pregs per cycle in slot order, takes back pregs
//   freed at commit, and restores the speculative read pointer to the
//   committed one on a pipeline flush.
//
//   Ports
//     clk, resetn          clock; asynchronous active-low reset
//     alloc_req[FW]        slot i needs a destination preg
//     alloc_ack            rename advances this cycle (pops granted ids)
//     alloc_ok             every requesting slot can be served
//     pdst_valid[FW]       alloc_req gated by alloc_ok
//     pdst_id[FW*PREG_W]   preg id per slot, 0 for non-requesting slots
//     rel_valid/rel_id     pregs freed at commit, appended at tail
//     cmt_cnt              allocating instructions retiring this cycle
//     flush                recovery: speculative state <- committed state
//     free_cnt             speculative free entries
module free_list #(
    parameter int FETCH_WIDTH = 2,
    parameter int AREG_NUM    = 32,
    parameter int PREG_NUM    = 64,
    parameter int PREG_W      = $clog2(PREG_NUM)
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [FETCH_WIDTH-1:0]                 alloc_req,
    input  logic                                   alloc_ack,
    output logic                                   alloc_ok,
    output logic [FETCH_WIDTH-1:0]                 pdst_valid,
    output logic [FETCH_WIDTH*PREG_W-1:0]          pdst_id,
    input  logic [FETCH_WIDTH-1:0]                 rel_valid,
    input  logic [FETCH_WIDTH*PREG_W-1:0]          rel_id,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]       cmt_cnt,
    input  logic                                   flush,
    output logic [$clog2(PREG_NUM-AREG_NUM+1)-1:0] free_cnt
);

    localparam int DEPTH = PREG_NUM - AREG_NUM;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SEL_W = $clog2(FETCH_WIDTH + 1);

    function automatic logic [SEL_W-1:0] popcnt(input logic [FETCH_WIDTH-1:0] v);
        logic [SEL_W-1:0] c;
        c = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            c = c + SEL_W'(v[i]);
        end
        return c;
    endfunction

    logic [PREG_W-1:0] entry [DEPTH];
    logic [PTR_W-1:0]  head, cmt_head, tail;
    logic [CNT_W-1:0]  count, cmt_count;

    logic [SEL_W-1:0]  n_req, n_rel, n_pop;
    logic [PTR_W-1:0]  cmt_head_nxt;
    logic [CNT_W-1:0]  count_nxt, cmt_count_nxt;
    logic [PTR_W-1:0]  wr_idx [FETCH_WIDTH];

    always_comb begin
        n_req         = popcnt(alloc_req);
        n_rel         = popcnt(rel_valid);
        // All-or-nothing grant: a partial allocation would split a rename group.
        alloc_ok      = (count >= CNT_W'(n_req)) && !flush;
        pdst_valid    = alloc_req & {FETCH_WIDTH{alloc_ok}};
        n_pop         = (alloc_ok && alloc_ack) ? n_req : '0;
        cmt_head_nxt  = cmt_head + PTR_W'(cmt_cnt);
        // Intermediate wrap is harmless: the final value is always in range.
        cmt_count_nxt = cmt_count - CNT_W'(cmt_cnt) + CNT_W'(n_rel);
        count_nxt     = count - CNT_W'(n_pop) + CNT_W'(n_rel);
    end

    // Requesting slots read consecutive entries from head in slot order.
    always_comb begin
        logic [PTR_W-1:0] rank;
        rank    = '0;
        pdst_id = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (alloc_req[i]) begin
                pdst_id[i*PREG_W +: PREG_W] = entry[head + rank];
                rank = rank + PTR_W'(1);
            end
        end
    end

    // Released ids are packed at tail by their rank among valid slots.
    always_comb begin
        logic [PTR_W-1:0] rank;
        rank = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_idx[i] = tail + rank;
            if (rel_valid[i]) begin
                rank = rank + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry[k] <= PREG_W'(AREG_NUM + k);
            end
            head      <= '0;
            cmt_head  <= '0;
            tail      <= '0;
            count     <= CNT_W'(DEPTH);
            cmt_count <= CNT_W'(DEPTH);
        end else begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (rel_valid[i]) begin
                    entry[wr_idx[i]] <= rel_id[i*PREG_W +: PREG_W];
                end
            end
            tail      <= tail + PTR_W'(n_rel);
            cmt_head  <= cmt_head_nxt;
            cmt_count <= cmt_count_nxt;
            // Flush restores to the committed view including this cycle's
            // commits and releases; alloc_ok is forced low so nothing pops.
            if (flush) begin
                head  <= cmt_head_nxt;
                count <= cmt_count_nxt;
            end else begin
                head  <= head + PTR_W'(n_pop);
                count <= count_nxt;
            end
        end
    end

    assign free_cnt = count;

    // cmt_count - count is the number of allocated but not yet retired ids;
    // retirement can never exceed it.
    always @(posedge clk) begin
        if (resetn) begin
            assert (count <= CNT_W'(DEPTH));
            assert (int'(count) + int'(n_rel) - int'(n_pop) <= DEPTH);
            assert (int'(cmt_count) - int'(cmt_cnt) + int'(n_rel) <= DEPTH);
            assert (int'(cmt_cnt) <= int'(cmt_count) - int'(count));
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (pdst_valid[i]) begin
                    assert (!$isunknown(pdst_id[i*PREG_W +: PREG_W]));
                end
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus randomized traffic checked
// against a queue-level model (speculative list, committed list, and a pool
// of architecturally held ids that supplies release traffic).
module tb_free_list;

    localparam int FW    = 2;
    localparam int AREG  = 32;
    localparam int PREG  = 64;
    localparam int PW    = 6;
    localparam int DEPTH = PREG - AREG;

    logic          clk = 1'b0;
    logic          resetn;
    logic [FW-1:0] alloc_req;
    logic          alloc_ack;
    logic          alloc_ok;
    logic [FW-1:0] pdst_valid;
    logic [FW*PW-1:0] pdst_id;
    logic [FW-1:0] rel_valid;
    logic [FW*PW-1:0] rel_id;
    logic [1:0]    cmt_cnt;
    logic          flush;
    logic [5:0]    free_cnt;

    free_list #(
        .FETCH_WIDTH(FW),
        .AREG_NUM   (AREG),
        .PREG_NUM   (PREG),
        .PREG_W     (PW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .alloc_req (alloc_req),
        .alloc_ack (alloc_ack),
        .alloc_ok  (alloc_ok),
        .pdst_valid(pdst_valid),
        .pdst_id   (pdst_id),
        .rel_valid (rel_valid),
        .rel_id    (rel_id),
        .cmt_cnt   (cmt_cnt),
        .flush     (flush),
        .free_cnt  (free_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int spec_q[$];
    int cmt_q[$];
    int arch[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick_arch();
        int idx;
        int id;
        idx = $urandom_range(0, arch.size() - 1);
        id  = arch[idx];
        arch.delete(idx);
        return id;
    endfunction

    task automatic model_reset();
        spec_q.delete();
        arch.delete();
        for (int k = 0; k < DEPTH; k++) spec_q.push_back(AREG + k);
        for (int k = 0; k < AREG; k++) arch.push_back(k);
        cmt_q = spec_q;
    endtask

    task automatic idle_inputs();
        alloc_req = '0;
        alloc_ack = 1'b0;
        rel_valid = '0;
        rel_id    = '0;
        cmt_cnt   = '0;
        flush     = 1'b0;
    endtask

    // Called just after a rising edge; the reset value must show before the
    // next edge, proving the reset is asynchronous.
    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        #2;
        check_eq("rst.free_cnt", free_cnt, DEPTH);
        alloc_req = 2'b11;
        #1;
        check_eq("rst.alloc_ok", alloc_ok, 1);
        alloc_req = '0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic step(input logic [1:0] req, input logic ack, input logic [1:0] rv,
                        input int r0, input int r1, input int cc, input logic fl,
                        input string tag);
        int   n;
        int   k;
        logic ok;
        alloc_req = req;
        alloc_ack = ack;
        rel_valid = rv;
        rel_id    = {PW'(r1), PW'(r0)};
        cmt_cnt   = 2'(cc);
        flush     = fl;
        @(negedge clk);
        n  = $countones(req);
        ok = (spec_q.size() >= n) && !fl;
        check_eq({tag, ".alloc_ok"}, alloc_ok, ok);
        check_eq({tag, ".pdst_valid"}, pdst_valid, ok ? req : 2'b00);
        check_eq({tag, ".free_cnt"}, free_cnt, spec_q.size());
        k = 0;
        for (int i = 0; i < FW; i++) begin
            if (req[i]) begin
                if (ok) check_eq({tag, ".pdst_id"}, pdst_id[i*PW +: PW], spec_q[k]);
                k++;
            end else begin
                check_eq({tag, ".pdst_zero"}, pdst_id[i*PW +: PW], 0);
            end
        end
        if (ok && ack) repeat (n) void'(spec_q.pop_front());
        repeat (cc) arch.push_back(cmt_q.pop_front());
        if (rv[0]) begin spec_q.push_back(r0); cmt_q.push_back(r0); end
        if (rv[1]) begin spec_q.push_back(r1); cmt_q.push_back(r1); end
        if (fl) spec_q = cmt_q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        @(posedge clk);
        #1;

        // Two-wide allocation straight out of reset.
        do_reset();
        step(2'b11, 1, 2'b00, 0, 0, 0, 0, "t1");
        step(2'b00, 0, 2'b00, 0, 0, 0, 0, "t1.after");

        // Only slot 1 requests: it gets the head entry.
        do_reset();
        step(2'b10, 1, 2'b00, 0, 0, 0, 0, "t2");
        step(2'b01, 1, 2'b00, 0, 0, 0, 0, "t2.next");

        // One entry left, two requested: stall; a release helps next cycle.
        do_reset();
        repeat (15) step(2'b11, 1, 2'b00, 0, 0, 0, 0, "t3.fill");
        step(2'b01, 1, 2'b00, 0, 0, 0, 0, "t3.fill1");
        step(2'b11, 1, 2'b00, 0, 0, 2, 0, "t3.stall");
        step(2'b11, 1, 2'b01, pick_arch(), 0, 0, 0, "t3.rel");
        step(2'b11, 1, 2'b00, 0, 0, 0, 0, "t3.go");

        // Flush rewinds to the committed head, dropping same-cycle allocation.
        do_reset();
        step(2'b11, 1, 2'b00, 0, 0, 0, 0, "t4.a");
        step(2'b11, 1, 2'b00, 0, 0, 0, 0, "t4.b");
        step(2'b11, 1, 2'b00, 0, 0, 2, 1, "t4.flush");
        step(2'b01, 1, 2'b00, 0, 0, 0, 0, "t4.after");

        // Move tail to DEPTH-1, then a two-id release wraps around.
        do_reset();
        for (int j = 0; j < 15; j++) begin
            step(2'b11, 1, 2'b00, 0, 0, 0, 0, "t5.alloc");
            step(2'b00, 0, 2'b11, pick_arch(), pick_arch(), 2, 0, "t5.rel");
        end
        step(2'b01, 1, 2'b00, 0, 0, 0, 0, "t5.alloc1");
        step(2'b00, 0, 2'b01, pick_arch(), 0, 1, 0, "t5.rel1");
        step(2'b11, 1, 2'b00, 0, 0, 0, 0, "t5.alloc2");
        step(2'b00, 0, 2'b11, pick_arch(), pick_arch(), 2, 0, "t5.wrap");
        repeat (16) step(2'b11, 1, 2'b00, 0, 0, 0, 0, "t5.drain");

        // Empty list: same-cycle release is not bypassed to allocation.
        do_reset();
        repeat (16) step(2'b11, 1, 2'b00, 0, 0, 0, 0, "t6.fill");
        step(2'b01, 1, 2'b11, pick_arch(), pick_arch(), 2, 0, "t6.same");
        step(2'b01, 1, 2'b00, 0, 0, 0, 0, "t6.next");

        // Randomized traffic with a mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            automatic logic [1:0] req = 2'($urandom);
            automatic logic       ack = ($urandom_range(0, 3) != 0);
            automatic logic       fl  = ($urandom_range(0, 31) == 0);
            automatic int inflight = cmt_q.size() - spec_q.size();
            automatic int kc = $urandom_range(0, (inflight < 2) ? inflight : 2);
            automatic int rmax = DEPTH - cmt_q.size() + kc;
            automatic int r;
            automatic logic [1:0] rv;
            automatic int r0;
            automatic int r1;
            if (rmax > 2) rmax = 2;
            r = $urandom_range(0, rmax);
            if (r == 0) rv = 2'b00;
            else if (r == 2) rv = 2'b11;
            else rv = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            r0 = rv[0] ? pick_arch() : 0;
            r1 = rv[1] ? pick_arch() : 0;
            step(req, ack, rv, r0, r1, kc, fl, "rnd");
            if (c == 1500) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
